// File: rtl/fifo_drain_packer_if.sv
// Interface bundling the FIFO read port, the flush request and the packed
// valid/ready output of fifo_drain_packer.
//   master : the packer (drives fifo_rd_en and the out_* word)
//   slave  : FIFO + downstream consumer (drives fifo_empty/fifo_data, flush, out_ready)
interface fifo_drain_packer_if #(
    parameter int unsigned WIDTH_DATA = 4,
    parameter int unsigned PACK       = 4
);
    logic                         fifo_empty;
    logic [WIDTH_DATA-1:0]        fifo_data;
    logic                         fifo_rd_en;
    logic                         flush;
    logic [WIDTH_DATA*PACK-1:0]   out_data;
    logic [PACK-1:0]              out_keep;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en,
        input  flush,
        output out_data,
        output out_keep,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en,
        output flush,
        input  out_data,
        input  out_keep,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fifo_drain_packer.sv
// Read-side consumer of a dual-clock FIFO: drains narrow entries (one-cycle
// registered read latency), packs PACK of them into one wide word (lane 0 in
// the LSBs) and presents it on a valid/ready output. A flush pulse emits the
// current partial word with a lane-keep mask.
// Ports:
//   rd_clk   : read-domain clock, the only clock
//   rd_rst_n : asynchronous active-low reset
//   bus      : master side of fifo_drain_packer_if (FIFO read port, flush,
//              out_data/out_keep/out_valid/out_ready)
module fifo_drain_packer #(
    parameter int unsigned WIDTH_DATA = 4,
    parameter int unsigned PACK       = 4
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst_n,
    fifo_drain_packer_if.master  bus
);
    localparam int unsigned W_WORD = WIDTH_DATA * PACK;
    localparam int unsigned CW     = $clog2(PACK + 1);
    localparam int unsigned CW1    = CW + 1;

    typedef enum logic {
        FILL       = 1'b0,
        FLUSH_WAIT = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 rd_pend;
    logic [W_WORD-1:0]    acc, acc_nxt;
    logic [W_WORD-1:0]    out_data_q, out_data_nxt;
    logic [PACK-1:0]      out_keep_q, out_keep_nxt;
    logic                 out_valid_q, out_valid_nxt;

    logic                 rd_en_c;
    logic                 slot_free_c;
    logic                 flush_req_c;
    logic                 emit_c;
    logic [PACK-1:0]      keep_c;
    logic [W_WORD-1:0]    emit_data_c;
    logic [CW-1:0]        wr_lane_c;
    logic [CW-1:0]        cnt_base_c;

    // Pending flush is exactly the FLUSH_WAIT state.
    assign flush_req_c = (state == FLUSH_WAIT);
    assign slot_free_c = !out_valid_q || bus.out_ready;

    // Read strobe: never while empty, never while a flush is pending, and only
    // when the accumulator has room for everything already in flight.
    assign rd_en_c = rd_rst_n && !bus.fifo_empty && (state == FILL) &&
                     ((CW1'(cnt) + CW1'(rd_pend)) < CW1'(PACK));
    assign bus.fifo_rd_en = rd_en_c;

    assign bus.out_data  = out_data_q;
    assign bus.out_keep  = out_keep_q;
    assign bus.out_valid = out_valid_q;

    // Keep mask covers lanes below cnt; with cnt==PACK this is all ones, so a
    // full transfer and a flush share one path.
    always_comb begin
        keep_c      = '0;
        emit_data_c = '0;
        for (int i = 0; i < int'(PACK); i++) begin
            keep_c[i] = (CW'(i) < cnt);
            if (keep_c[i]) begin
                emit_data_c[i*WIDTH_DATA +: WIDTH_DATA] = acc[i*WIDTH_DATA +: WIDTH_DATA];
            end
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        acc_nxt       = acc;
        out_data_nxt  = out_data_q;
        out_keep_nxt  = out_keep_q;
        out_valid_nxt = out_valid_q && !bus.out_ready;
        emit_c        = 1'b0;
        wr_lane_c     = cnt;
        cnt_base_c    = cnt;

        case (state)
            FILL: begin
                if (bus.flush) begin
                    state_nxt = FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                if (slot_free_c && !rd_pend) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase

        if (slot_free_c && ((cnt == CW'(PACK)) ||
                            (flush_req_c && !rd_pend && (cnt != '0)))) begin
            emit_c = 1'b1;
        end

        if (emit_c) begin
            out_data_nxt  = emit_data_c;
            out_keep_nxt  = keep_c;
            out_valid_nxt = 1'b1;
            wr_lane_c     = '0;
            cnt_base_c    = '0;
        end

        // Registered FIFO data lands one cycle after the strobe.
        cnt_nxt = cnt_base_c;
        if (rd_pend) begin
            for (int i = 0; i < int'(PACK); i++) begin
                if (CW'(i) == wr_lane_c) begin
                    acc_nxt[i*WIDTH_DATA +: WIDTH_DATA] = bus.fifo_data;
                end
            end
            cnt_nxt = cnt_base_c + CW'(1);
        end
    end

    // State register.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state       <= FILL;
            cnt         <= '0;
            rd_pend     <= 1'b0;
            acc         <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rd_pend     <= rd_en_c;
            acc         <= acc_nxt;
            out_data_q  <= out_data_nxt;
            out_keep_q  <= out_keep_nxt;
            out_valid_q <= out_valid_nxt;
        end
    end
endmodule

// File: tb/tb_fifo_drain_packer.sv
// Directed self-checking bench for fifo_drain_packer (WIDTH_DATA=4, PACK=4).
module tb_fifo_drain_packer;
    logic rd_clk;
    logic rd_rst_n;

    fifo_drain_packer_if #(.WIDTH_DATA(4), .PACK(4)) bus ();

    fifo_drain_packer #(.WIDTH_DATA(4), .PACK(4)) dut (
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .bus      (bus)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    int checks;
    int errors;

    // FIFO model with one-cycle registered read data.
    logic [3:0] fmem [0:63];
    logic [5:0] wr_ptr;
    logic [5:0] rd_ptr;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge rd_clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_data <= fmem[rd_ptr];
            rd_ptr        <= rd_ptr + 6'd1;
        end
    end

    // Monitor: accepted words, read strobes, cycle stamps.
    int         cyc;
    int         n_rd;
    int         last_rd_cyc;
    int         n_acc;
    int         acc_cyc  [0:63];
    logic [15:0] acc_data [0:63];
    logic [3:0]  acc_keep [0:63];

    always @(posedge rd_clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_rd_en) begin
            n_rd        <= n_rd + 1;
            last_rd_cyc <= cyc;
        end
        if (rd_rst_n && bus.out_valid && bus.out_ready) begin
            acc_data[n_acc] <= bus.out_data;
            acc_keep[n_acc] <= bus.out_keep;
            acc_cyc[n_acc]  <= cyc;
            n_acc           <= n_acc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge rd_clk);
    endtask

    task automatic push(input logic [3:0] v);
        fmem[wr_ptr] = v;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic wait_words(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && n_acc < target; i++) @(negedge rd_clk);
        check(tag, 32'(n_acc), 32'(target));
    endtask

    int base_rd;
    int base_acc;

    initial begin
        checks       = 0;
        errors       = 0;
        wr_ptr       = '0;
        rd_ptr       = '0;
        cyc          = 0;
        n_rd         = 0;
        last_rd_cyc  = 0;
        n_acc        = 0;
        bus.fifo_data = '0;
        bus.flush    = 1'b0;
        bus.out_ready = 1'b1;
        rd_rst_n     = 1'b0;

        // Reset hold, then idle with an empty FIFO.
        tick(3);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_keep",  32'(bus.out_keep),  32'h0);
        check("rst_data",  32'(bus.out_data),  32'h0);
        check("rst_rd_en", 32'(bus.fifo_rd_en), 32'h0);
        rd_rst_n = 1'b1;
        tick(10);
        check("idle_valid", 32'(bus.out_valid), 32'h0);
        check("idle_keep",  32'(bus.out_keep),  32'h0);
        check("idle_reads", 32'(n_rd), 32'h0);

        // Four entries, one full word.
        base_rd = n_rd;
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        wait_words("w1_count", 1, 40);
        check("w1_reads", 32'(n_rd - base_rd), 32'd4);
        check("w1_data",  32'(acc_data[0]), 32'h4321);
        check("w1_keep",  32'(acc_keep[0]), 32'hf);
        check("w1_latency", 32'(acc_cyc[0] - last_rd_cyc), 32'd3);

        // Backpressure: 12 entries with out_ready low.
        tick(2);
        bus.out_ready = 1'b0;
        base_rd  = n_rd;
        base_acc = n_acc;
        for (int i = 0; i < 12; i++) push(4'(i));
        tick(20);
        check("bp_valid", 32'(bus.out_valid), 32'h1);
        check("bp_data",  32'(bus.out_data),  32'h3210);
        check("bp_keep",  32'(bus.out_keep),  32'hf);
        check("bp_stall_reads", 32'(n_rd - base_rd), 32'd8);
        check("bp_rd_en_low", 32'(bus.fifo_rd_en), 32'h0);
        bus.out_ready = 1'b1;
        wait_words("bp_count", base_acc + 3, 60);
        check("bp_w0", 32'(acc_data[base_acc]),     32'h3210);
        check("bp_w1", 32'(acc_data[base_acc + 1]), 32'h7654);
        check("bp_w2", 32'(acc_data[base_acc + 2]), 32'hba98);
        check("bp_k2", 32'(acc_keep[base_acc + 2]), 32'hf);

        // Partial word via flush: 5,6,7 then flush.
        tick(3);
        base_rd  = n_rd;
        base_acc = n_acc;
        push(4'h5); push(4'h6); push(4'h7);
        for (int i = 0; i < 20 && n_rd < base_rd + 3; i++) @(negedge rd_clk);
        check("fl_reads", 32'(n_rd - base_rd), 32'd3);
        tick(3);
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        push(4'h8);
        #1;
        check("fl_rd_blocked", 32'(bus.fifo_rd_en), 32'h0);
        wait_words("fl_count", base_acc + 1, 20);
        check("fl_data", 32'(acc_data[base_acc]), 32'h0765);
        check("fl_keep", 32'(acc_keep[base_acc]), 32'h7);
        // Entry 8 becomes lane 0 of the next word; flush it out alone.
        tick(4);
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        wait_words("fl1_count", base_acc + 2, 20);
        check("fl1_data", 32'(acc_data[base_acc + 1]), 32'h0008);
        check("fl1_keep", 32'(acc_keep[base_acc + 1]), 32'h1);

        // Flush with nothing accumulated: no word, reads resume next cycle.
        tick(3);
        base_acc = n_acc;
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        push(4'h9); push(4'ha); push(4'hb); push(4'hc);
        #1;
        check("f0_rd_blocked", 32'(bus.fifo_rd_en), 32'h0);
        tick(1);
        check("f0_rd_resume", 32'(bus.fifo_rd_en), 32'h1);
        check("f0_no_word", 32'(n_acc), 32'(base_acc));
        wait_words("f0_count", base_acc + 1, 30);
        check("f0_data", 32'(acc_data[base_acc]), 32'hcba9);

        // Reset mid-word (cnt=2, one read in flight).
        tick(3);
        base_rd  = n_rd;
        base_acc = n_acc;
        push(4'hd); push(4'he); push(4'hf);
        tick(3);
        check("mr_reads", 32'(n_rd - base_rd), 32'd3);
        rd_rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(bus.out_valid), 32'h0);
        check("mr_data",  32'(bus.out_data),  32'h0);
        check("mr_keep",  32'(bus.out_keep),  32'h0);
        tick(2);
        rd_rst_n = 1'b1;
        tick(2);
        check("mr_no_word", 32'(n_acc), 32'(base_acc));
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        wait_words("mr_count", base_acc + 1, 30);
        check("mr_data_new", 32'(acc_data[base_acc]), 32'h4321);
        check("mr_keep_new", 32'(acc_keep[base_acc]), 32'hf);
        tick(10);
        check("mr_single", 32'(n_acc), 32'(base_acc + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
